// File: rtl/ifetch32.sv
// ifetch32 - instruction fetch unit for the 32-bit core.
//
// Keeps at most one instruction-memory request in flight, buffers the
// returned words with their PCs in a small FIFO, and redirects the PC when
// decode accepts a taken branch. An epoch bit is flipped on every redirect so
// that words for requests issued before the redirect are discarded when they
// return.
//
// Optional feature macro: IFETCH_BYPASS_EN
//   defined   - a valid-epoch word arriving while the FIFO is empty is shown
//               to decode in the same cycle (zero-latency bypass)
//   undefined - every returned word goes through the FIFO (latency 1)
//
// Decode handshake: a word moves to decode on a cycle where i_valid_out and
// i_ready_in are both high ("accept"). While i_valid_out is high, i_out and
// pc_out stay stable until accepted or until a redirect flushes them. The
// branch inputs ib_in/bv_in/bl_in are only looked at on an accept cycle.
module ifetch32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] i_out,
    output logic [31:0] pc_out,
    output logic        i_valid_out,
    input  logic        i_ready_in,
    input  logic        ib_in,
    input  logic [31:0] bv_in,
    input  logic        bl_in,
    output logic [31:0] lr_value_out,
    output logic        lr_we_out
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

    // Request-side state
    logic [31:0]      fetch_pc;
    logic             outstanding;
    logic             epoch;
    logic             req_epoch;

    // Prefetch FIFO of {instruction, pc}
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             ack_ok;
    logic             epoch_ok;
    logic             fifo_empty;
    logic             accept;
    logic             redirect;
    logic             push;
    logic             pop;
    logic             byp_take;
    logic [CNT_W:0]   occupancy;
    logic             space_ok;
    logic             issue;
    logic [31:0]      target;
    logic [31:0]      issue_addr;

    // An ack only means something while a request is actually in flight;
    // anything else (e.g. a late ack after reset) is ignored.
    assign ack_ok     = imem_ack_in & outstanding;
    assign epoch_ok   = (req_epoch == epoch);
    assign fifo_empty = (count == '0);

`ifdef IFETCH_BYPASS_EN
    logic byp_valid;
    assign byp_valid   = fifo_empty & ack_ok & epoch_ok;
    assign i_valid_out = ~fifo_empty | byp_valid;
    assign i_out       = byp_valid ? imem_data_in  : instr_q[rd_ptr];
    assign pc_out      = byp_valid ? imem_addr_out : pc_q[rd_ptr];
    assign byp_take    = byp_valid & accept;
`else
    assign i_valid_out = ~fifo_empty;
    assign i_out       = instr_q[rd_ptr];
    assign pc_out      = pc_q[rd_ptr];
    assign byp_take    = 1'b0;
`endif

    assign accept   = i_valid_out & i_ready_in;
    assign redirect = accept & ib_in;
    assign pop      = accept & ~fifo_empty;
    // A word returning in the redirect cycle belongs to the old path.
    assign push     = ack_ok & epoch_ok & ~redirect & ~byp_take;

    assign target       = pc_out + 32'd8 + bv_in;
    assign lr_value_out = pc_out + 32'd4;
    assign lr_we_out    = redirect & bl_in;

    // Space is reserved for the in-flight word so the FIFO cannot overflow.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
    assign space_ok  = (occupancy < DEPTH_C);

    // A redirect never issues from the old fetch_pc; it issues straight to
    // the branch target instead (the FIFO is being flushed, so space is
    // guaranteed). If a request is still in flight the target request waits
    // for that stale ack.
    assign issue      = (~outstanding | ack_ok) & (redirect | space_ok);
    assign issue_addr = {(redirect ? target[31:2] : fetch_pc[31:2]), 2'b00};

    assign imem_req_out = outstanding;

    // Request tracking: fetch PC, in-flight flag/address and epochs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            outstanding   <= 1'b0;
            imem_addr_out <= 32'h0;
            epoch         <= 1'b0;
            req_epoch     <= 1'b0;
        end else begin
            if (redirect) begin
                epoch <= ~epoch;
            end
            if (issue) begin
                outstanding   <= 1'b1;
                imem_addr_out <= issue_addr;
                req_epoch     <= redirect ? ~epoch : epoch;
                fetch_pc      <= issue_addr + 32'd4;
            end else begin
                if (ack_ok) begin
                    outstanding <= 1'b0;
                end
                if (redirect) begin
                    fetch_pc <= {target[31:2], 2'b00};
                end
            end
        end
    end

    // Prefetch FIFO: push returned words, pop on accept, flush on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 32'h0;
                pc_q[i]    <= 32'h0;
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= imem_data_in;
                pc_q[wr_ptr]    <= imem_addr_out;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_ifetch32.sv
// tb_ifetch32 - directed bench for ifetch32 (default parameters).
// A behavioural memory answers requests after a configurable delay with a
// word derived from the address; branch redirects are driven from a table.
module tb_ifetch32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;
    logic [31:0] i_out;
    logic [31:0] pc_out;
    logic        i_valid_out;
    logic        i_ready_in;
    logic        ib_in;
    logic [31:0] bv_in;
    logic        bl_in;
    logic [31:0] lr_value_out;
    logic        lr_we_out;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_delay = 0;
    bit resp_hold = 1'b0;

    typedef struct {
        logic [31:0] br_pc;
        logic [31:0] bv;
        logic        bl;
        logic [31:0] exp_target;
        logic [31:0] exp_lr;
    } br_vec_t;

    br_vec_t tbl [6];

    ifetch32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_out (imem_req_out),
        .imem_addr_out(imem_addr_out),
        .imem_ack_in  (imem_ack_in),
        .imem_data_in (imem_data_in),
        .i_out        (i_out),
        .pc_out       (pc_out),
        .i_valid_out  (i_valid_out),
        .i_ready_in   (i_ready_in),
        .ib_in        (ib_in),
        .bv_in        (bv_in),
        .bl_in        (bl_in),
        .lr_value_out (lr_value_out),
        .lr_we_out    (lr_we_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample point: just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: answers the outstanding request after ack_delay idle cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        imem_ack_in  = 1'b0;
        imem_data_in = 32'h0;
        forever begin
            @(negedge clk);
            if (!resp_hold) begin
                imem_ack_in = 1'b0;
                if (!rst_n || !imem_req_out) begin
                    wcnt = 0;
                end else if (wcnt >= ack_delay) begin
                    imem_ack_in  = 1'b1;
                    imem_data_in = mem_word(imem_addr_out);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Wait for pc br_pc, take the branch, then check the redirect behaviour.
    task automatic do_branch(input br_vec_t v, input int exp_stale);
        int  guard;
        int  stale;
        bit  seen_req;
        bit  found;
        guard = 0;
        while (!(i_valid_out && pc_out == v.br_pc) && guard < 400) begin
            tick();
            guard++;
        end
        check32("reach_br_pc", 32'(guard < 400), 32'd1);
        if (guard >= 400) return;
        ib_in = 1'b1;
        bv_in = v.bv;
        bl_in = v.bl;
        #1;
        check32("lr_value", lr_value_out, v.exp_lr);
        check32("lr_we", 32'(lr_we_out), 32'(v.bl));
        @(posedge clk);
        #1;
        ib_in = 1'b0;
        bl_in = 1'b0;
        bv_in = 32'h0;
        stale = 0;
        seen_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (k > 0 && imem_ack_in && !seen_req) stale++;
            if (!seen_req && imem_req_out && imem_addr_out == v.exp_target) begin
                seen_req = 1'b1;
                check32("tgt_req_timing", 32'(k == 0 || imem_ack_in), 32'd1);
            end
            if (i_valid_out) begin
                found = 1'b1;
                check32("tgt_pc", pc_out, v.exp_target);
                check32("tgt_instr", i_out, mem_word(v.exp_target));
                check32("tgt_req_seen", 32'(seen_req), 32'd1);
            end else begin
                tick();
            end
        end
        check32("tgt_valid", 32'(found), 32'd1);
        check32("stale_acks", 32'(stale), 32'(exp_stale));
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int got;
        br_vec_t sv;

        tbl[0] = '{br_pc: 32'h0000_0040, bv: 32'h0000_0010, bl: 1'b1, exp_target: 32'h0000_0058, exp_lr: 32'h0000_0044};
        tbl[1] = '{br_pc: 32'h0000_0100, bv: 32'hFFFF_FFF8, bl: 1'b0, exp_target: 32'h0000_0100, exp_lr: 32'h0000_0104};
        tbl[2] = '{br_pc: 32'h0000_0104, bv: 32'hFFFF_FEF0, bl: 1'b0, exp_target: 32'hFFFF_FFFC, exp_lr: 32'h0000_0108};
        tbl[3] = '{br_pc: 32'hFFFF_FFFC, bv: 32'h0000_0000, bl: 1'b1, exp_target: 32'h0000_0004, exp_lr: 32'h0000_0000};
        tbl[4] = '{br_pc: 32'h0000_0008, bv: 32'h7FFF_FFF0, bl: 1'b0, exp_target: 32'h8000_0000, exp_lr: 32'h0000_000C};
        tbl[5] = '{br_pc: 32'h8000_0000, bv: 32'h0000_0008, bl: 1'b1, exp_target: 32'h8000_0010, exp_lr: 32'h8000_0004};

        // Clock/reset
        rst_n = 1'b0;
        i_ready_in = 1'b0;
        ib_in = 1'b0;
        bv_in = 32'h0;
        bl_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_req", 32'(imem_req_out), 32'd0);
        check32("rst_addr", imem_addr_out, 32'h0);
        check32("rst_valid", 32'(i_valid_out), 32'd0);
        check32("rst_i_out", i_out, 32'h0);
        check32("rst_pc_out", pc_out, 32'h0);
        check32("rst_lr_value", lr_value_out, 32'h4);
        check32("rst_lr_we", 32'(lr_we_out), 32'd0);

        rst_n = 1'b1;
        tick();
        check32("first_req", 32'(imem_req_out), 32'd1);
        check32("first_addr", imem_addr_out, 32'h0);

        // Decode stalled: FIFO fills to DEPTH and requests stop.
        repeat (10) tick();
        check32("stall_valid", 32'(i_valid_out), 32'd1);
        check32("stall_pc", pc_out, 32'h0);
        check32("stall_instr", i_out, mem_word(32'h0));
        check32("stall_req_low", 32'(imem_req_out), 32'd0);

        // Spurious ack with nothing outstanding must be ignored.
        resp_hold = 1'b1;
        @(negedge clk);
        imem_ack_in  = 1'b1;
        imem_data_in = 32'hDEAD_DEAD;
        @(negedge clk);
        imem_ack_in = 1'b0;
        resp_hold = 1'b0;
        tick();
        check32("idle_ack_req", 32'(imem_req_out), 32'd0);

        // Drain in order: 0x0, 0x4 from the FIFO, then 0x8, 0xC fetched.
        i_ready_in = 1'b1;
        got = 0;
        for (int k = 0; k < 60 && got < 4; k++) begin
            if (i_valid_out) begin
                check32("drain_pc", pc_out, 32'(got * 4));
                check32("drain_instr", i_out, mem_word(32'(got * 4)));
                got++;
            end
            tick();
        end
        check32("drain_count", 32'(got), 32'd4);

        // Table-driven branch redirects (memory acks every cycle).
        for (int i = 0; i < 6; i++) begin
            do_branch(tbl[i], 0);
        end

        // Reset mid-operation with ack held high through release.
        ack_delay = 3;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check32("midrst_req", 32'(imem_req_out), 32'd0);
        check32("midrst_valid", 32'(i_valid_out), 32'd0);
        check32("midrst_pc", pc_out, 32'h0);
        resp_hold = 1'b1;
        imem_ack_in  = 1'b1;
        imem_data_in = 32'hBAD0_BAD0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check32("restart_req", 32'(imem_req_out), 32'd1);
        check32("restart_addr", imem_addr_out, 32'h0);
        imem_ack_in = 1'b0;
        resp_hold = 1'b0;
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            if (i_valid_out) begin
                check32("restart_pc", pc_out, 32'h0);
                check32("restart_instr", i_out, mem_word(32'h0));
                got = 1;
            end else begin
                tick();
            end
        end
        check32("restart_seen", 32'(got), 32'd1);

        // Redirect while the request to 0x20 is in flight (slow memory).
        sv = '{br_pc: 32'h0000_001C, bv: 32'h0000_01DC, bl: 1'b0, exp_target: 32'h0000_0200, exp_lr: 32'h0000_0020};
        do_branch(sv, 1);
        tick();
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            if (i_valid_out) begin
                check32("post_tgt_pc", pc_out, 32'h0000_0204);
                got = 1;
            end else begin
                tick();
            end
        end
        check32("post_tgt_seen", 32'(got), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
